// File: rtl/decode_stage_pl.sv
// Registered ID stage: IF/ID register, RV32 control/immediate decode, bypassed register file, load-use detect.
// Optional build macro PACKED_IMM_EN selects packed-lane immediates for funct7 7'b1110111.
module decode_stage_pl #(
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int REG_COUNT     = 32,
  localparam int RA_W          = $clog2(REG_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_f,
  input  logic [31:0]              instr_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     reg_write_w,
  input  logic [RA_W-1:0]          rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  input  logic                     mem_read_e,
  input  logic [RA_W-1:0]          rd_e,
  output logic                     valid_d,
  output logic                     hazard_d,
  output logic                     reg_write_d,
  output logic                     mem_write_d,
  output logic                     jump_d,
  output logic                     branch_d,
  output logic [1:0]               res_src_d,
  output logic [4:0]               alu_control_d,
  output logic [2:0]               funct3_d,
  output logic                     alu_src_a_d,
  output logic                     alu_src_b_d,
  output logic                     adder_src_d,
  output logic [DATA_WIDTH-1:0]    rd1_d,
  output logic [DATA_WIDTH-1:0]    rd2_d,
  output logic [RA_W-1:0]          rs1_d,
  output logic [RA_W-1:0]          rs2_d,
  output logic [RA_W-1:0]          rd_d,
  output logic [DATA_WIDTH-1:0]    imm_val_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_e;

  logic                     valid_q;
  logic [31:0]              instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
  logic [DATA_WIDTH-1:0]    regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (!rst_n || flush_d) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (!stall_d) begin
      valid_q    <= valid_f;
      instr_q    <= instr_f;
      pc_q       <= pc_f;
      pc_plus4_q <= pc_plus4_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (reg_write_w && rd_w != '0) begin
      regs[rd_w] <= result_w;
    end
  end

  logic     reg_write_raw, mem_write_raw, jump_raw, branch_raw, alt;
  imm_src_e imm_src;

  assign funct3_d = instr_q[14:12];

  // alu_control = {compare, alt (sub/sra), funct3}; compare marks branch comparisons
  always_comb begin
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    jump_raw      = 1'b0;
    branch_raw    = 1'b0;
    res_src_d     = 2'b00;
    alu_control_d = 5'b00000;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 1'b0;
    adder_src_d   = 1'b0;
    imm_src       = IMM_I;
    alt           = 1'b0;
    case (instr_q[6:0])
      OP_LOAD:   begin reg_write_raw = 1'b1; res_src_d = 2'b01; alu_src_b_d = 1'b1; end
      OP_STORE:  begin mem_write_raw = 1'b1; alu_src_b_d = 1'b1; imm_src = IMM_S; end
      OP_REG: begin
        reg_write_raw = 1'b1;
        alt           = instr_q[30] && (funct3_d == 3'b000 || funct3_d == 3'b101);
        alu_control_d = {1'b0, alt, funct3_d};
      end
      OP_IMM: begin
        reg_write_raw = 1'b1;
        alu_src_b_d   = 1'b1;
        alt           = instr_q[30] && funct3_d == 3'b101;
        alu_control_d = {1'b0, alt, funct3_d};
      end
      OP_BRANCH: begin branch_raw = 1'b1; imm_src = IMM_B; alu_control_d = {2'b10, funct3_d}; end
      OP_JAL:    begin jump_raw = 1'b1; reg_write_raw = 1'b1; res_src_d = 2'b10; imm_src = IMM_J; end
      OP_JALR: begin
        jump_raw      = 1'b1;
        reg_write_raw = 1'b1;
        res_src_d     = 2'b10;
        alu_src_b_d   = 1'b1;
        adder_src_d   = 1'b1;
      end
      OP_LUI:    begin reg_write_raw = 1'b1; res_src_d = 2'b11; alu_src_b_d = 1'b1; imm_src = IMM_U; end
      OP_AUIPC: begin
        reg_write_raw = 1'b1;
        alu_src_a_d   = 1'b1;
        alu_src_b_d   = 1'b1;
        imm_src       = IMM_U;
      end
      default: ;
    endcase
  end

  assign valid_d     = valid_q;
  assign reg_write_d = valid_q && reg_write_raw;
  assign mem_write_d = valid_q && mem_write_raw;
  assign jump_d      = valid_q && jump_raw;
  assign branch_d    = valid_q && branch_raw;

  logic signed [31:0]    imm32;
  logic [DATA_WIDTH-1:0] imm_ext_val;

  always_comb begin
    imm32 = '0;
    case (imm_src)
      IMM_S:   imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B:   imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      IMM_U:   imm32 = {instr_q[31:12], 12'h000};
      default: imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
    endcase
    imm_ext_val = DATA_WIDTH'(imm32);
  end

`ifdef PACKED_IMM_EN
  always_comb begin
    imm_val_d = imm_ext_val;
    if (instr_q[31:25] == 7'b1110111)
      imm_val_d = instr_q[14] ? DATA_WIDTH'(instr_q[23:20]) : DATA_WIDTH'(instr_q[24:20]);
  end
`else
  assign imm_val_d = imm_ext_val;
`endif

  assign rs1_d = instr_q[15 +: RA_W];
  assign rs2_d = instr_q[20 +: RA_W];
  assign rd_d  = instr_q[7 +: RA_W];

  // A non-zero source matching rd_w implies rd_w != 0, so the x0 rule needs no extra term
  always_comb begin
    if (rs1_d == '0)                          rd1_d = '0;
    else if (reg_write_w && rd_w == rs1_d)    rd1_d = result_w;
    else                                      rd1_d = regs[rs1_d];
    if (rs2_d == '0)                          rd2_d = '0;
    else if (reg_write_w && rd_w == rs2_d)    rd2_d = result_w;
    else                                      rd2_d = regs[rs2_d];
  end

  assign hazard_d   = valid_q && mem_read_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
  assign pc_d       = pc_q;
  assign pc_plus4_d = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage_pl.sv
// Bench for decode_stage_pl: directed scenarios then random traffic against an instruction-level model.
module tb_decode_stage_pl;

  logic        clk = 1'b0;
  logic        rst_n, valid_f, stall_d, flush_d, reg_write_w, mem_read_e;
  logic [31:0] instr_f, pc_f, pc_plus4_f, result_w;
  logic [4:0]  rd_w, rd_e;
  logic        valid_d, hazard_d, reg_write_d, mem_write_d, jump_d, branch_d;
  logic [1:0]  res_src_d;
  logic [4:0]  alu_control_d;
  logic [2:0]  funct3_d;
  logic        alu_src_a_d, alu_src_b_d, adder_src_d;
  logic [31:0] rd1_d, rd2_d, imm_val_d, pc_d, pc_plus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  decode_stage_pl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f),
    .pc_plus4_f(pc_plus4_f), .stall_d(stall_d), .flush_d(flush_d), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .mem_read_e(mem_read_e), .rd_e(rd_e),
    .valid_d(valid_d), .hazard_d(hazard_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .jump_d(jump_d), .branch_d(branch_d), .res_src_d(res_src_d), .alu_control_d(alu_control_d),
    .funct3_d(funct3_d), .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d),
    .adder_src_d(adder_src_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .imm_val_d(imm_val_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: what the ID slot should hold and what each register should contain
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_pc4;
  logic [31:0] m_regs [32];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] pack_obs();
    return {62'b0, valid_d, hazard_d, reg_write_d, mem_write_d, jump_d, branch_d, res_src_d,
            alu_control_d, funct3_d, alu_src_a_d, alu_src_b_d, adder_src_d, rd1_d, rd2_d,
            rs1_d, rs2_d, rd_d, imm_val_d, pc_d, pc_plus4_d};
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (reg_write_w && rd_w == r) return result_w;
    return m_regs[r];
  endfunction

  function automatic logic [255:0] model_out();
    logic [31:0] in  = m_instr;
    int          sx  = int'(in);
    int          opc = int'(in & 32'h7f);
    int          f3  = int'((in >> 12) & 32'd7);
    logic [4:0]  rs1 = 5'((in >> 15) & 32'd31);
    logic [4:0]  rs2 = 5'((in >> 20) & 32'd31);
    logic [4:0]  rd  = 5'((in >> 7) & 32'd31);
    bit ld = (opc == 'h03), st = (opc == 'h23), op = (opc == 'h33), opi = (opc == 'h13);
    bit br = (opc == 'h63), jal = (opc == 'h6f), jalr = (opc == 'h67);
    bit lui = (opc == 'h37), auipc = (opc == 'h17);
    bit rg = ld || op || opi || jal || jalr || lui || auipc;
    logic [1:0]  res;
    logic [4:0]  alu;
    logic [31:0] imm;
    bit hz;
    res = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
    alu = 5'd0;
    if (br) alu = 5'(16 + f3);
    else if (op || opi) begin
      alu = 5'(f3);
      if (in[30] && (f3 == 5 || (op && f3 == 0))) alu = alu + 5'd8;
    end
    if (st)               imm = 32'((sx >>> 25) * 32) + ((in >> 7) & 32'd31);
    else if (br)          imm = 32'((sx >>> 31) * 4096) + (((in >> 7) & 32'd1) << 11)
                              + (((in >> 25) & 32'd63) << 5) + (((in >> 8) & 32'd15) << 1);
    else if (jal)         imm = 32'((sx >>> 31) * 1048576) + (((in >> 12) & 32'd255) << 12)
                              + (((in >> 20) & 32'd1) << 11) + (((in >> 21) & 32'd1023) << 1);
    else if (lui || auipc) imm = in & 32'hFFFF_F000;
    else                  imm = 32'(sx >>> 20);
`ifdef PACKED_IMM_EN
    if ((in >> 25) == 32'h77) imm = in[14] ? ((in >> 20) & 32'd15) : ((in >> 20) & 32'd31);
`endif
    hz = m_valid && mem_read_e && rd_e != 0 && (rd_e == rs1 || rd_e == rs2);
    return {62'b0, m_valid, hz, m_valid && rg, m_valid && st, m_valid && (jal || jalr), m_valid && br,
            res, alu, 3'(f3), auipc, (ld || st || opi || jalr || auipc || lui), jalr,
            read_reg(rs1), read_reg(rs2), rs1, rs2, rd, imm, m_pc, m_pc4};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_valid = 0; m_instr = 32'h13; m_pc = 0; m_pc4 = 0;
    end else begin
      if (reg_write_w && rd_w != 0) m_regs[rd_w] = result_w;
      if (flush_d) begin
        m_valid = 0; m_instr = 32'h13; m_pc = 0; m_pc4 = 0;
      end else if (!stall_d) begin
        m_valid = valid_f; m_instr = instr_f; m_pc = pc_f; m_pc4 = pc_plus4_f;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f, 7'h0b};
    logic [31:0] w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h33) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) w[31:25] = 7'h77;
    return w;
  endfunction

  initial begin
    rst_n = 0; valid_f = 0; instr_f = 0; pc_f = 0; pc_plus4_f = 0; stall_d = 0; flush_d = 0;
    reg_write_w = 0; rd_w = 0; result_w = 0; mem_read_e = 0; rd_e = 0;
    m_valid = 0; m_instr = 32'h13; m_pc = 0; m_pc4 = 0;
    foreach (m_regs[i]) m_regs[i] = 32'd0;

    tick();
    check("rst_valid", valid_d, 0);
    check("rst_reg_write", reg_write_d, 0);
    check("rst_imm", imm_val_d, 0);
    check("rst_rd1_rd2", {rd1_d, rd2_d}, 0);
    check("rst_pc", pc_d, 0);
    check("rst_model", pack_obs(), model_out());

    rst_n = 1; valid_f = 1; instr_f = 32'h0070_0293; pc_f = 32'h100; pc_plus4_f = 32'h104;
    tick();
    check("addi_reg_write", reg_write_d, 1);
    check("addi_rd", rd_d, 5);
    check("addi_imm", imm_val_d, 7);
    check("addi_src_b", alu_src_b_d, 1);
    check("addi_model", pack_obs(), model_out());

    instr_f = 32'h0063_03B3;
    tick();
    reg_write_w = 1; rd_w = 6; result_w = 32'hDEAD_BEEF; #1;
    check("bypass_rd1_rd2", {rd1_d, rd2_d}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    stall_d = 1;
    tick();
    reg_write_w = 0; #1;
    check("array_rd1", rd1_d, 32'hDEAD_BEEF);
    check("array_model", pack_obs(), model_out());
    stall_d = 0;

    instr_f = 32'h0070_0293;
    tick();
    reg_write_w = 1; rd_w = 0; result_w = 5; #1;
    check("x0_bypass", rd1_d, 0);
    tick();
    reg_write_w = 0; #1;
    check("x0_array", rd1_d, 0);

    instr_f = 32'h0013_03B3; pc_f = 32'h200; pc_plus4_f = 32'h204;
    tick();
    mem_read_e = 1; rd_e = 6; #1;
    check("load_use_hazard", hazard_d, 1);
    stall_d = 1; instr_f = 32'h0070_0293; pc_f = 32'h300; pc_plus4_f = 32'h304;
    tick();
    check("stall1_hold", {pc_d, 27'b0, rs2_d}, {32'h200, 32'd1});
    tick();
    check("stall2_hold", {pc_d, 27'b0, rs2_d, 31'b0, hazard_d}, {32'h200, 32'd1, 32'd1});
    check("stall_model", pack_obs(), model_out());

    flush_d = 1; instr_f = 32'h0013_03B3;
    tick();
    check("stall_flush_bubble", {valid_d, reg_write_d, hazard_d}, 3'b000);
    flush_d = 0; stall_d = 0; mem_read_e = 0;

    instr_f = 32'hEE54_4033;
    tick();
    check("packed_model", pack_obs(), model_out());
`ifdef PACKED_IMM_EN
    check("packed_lane8_imm", imm_val_d, 5);
`endif

    stall_d = 1;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; #1;
    check("reset_mid_stall", valid_d, 0);
    stall_d = 0;

    for (int n = 0; n < 400; n++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      valid_f     = ($urandom_range(0, 3) != 0);
      instr_f     = rand_instr();
      pc_f        = $urandom & 32'hFFFF_FFFC;
      pc_plus4_f  = pc_f + 32'd4;
      stall_d     = ($urandom_range(0, 4) == 0);
      flush_d     = ($urandom_range(0, 9) == 0);
      reg_write_w = ($urandom_range(0, 1) != 0);
      rd_w        = ($urandom_range(0, 2) == 0) ? m_instr[19:15] : 5'($urandom);
      result_w    = $urandom;
      mem_read_e  = ($urandom_range(0, 1) != 0);
      rd_e        = ($urandom_range(0, 2) == 0) ? m_instr[24:20] : 5'($urandom);
      #1;
      check("random_cycle", pack_obs(), model_out());
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
